// File: rtl/ulpb_def.sv
// Shared ULPB layer-controller definitions: bus widths, FSM encodings
// and the RX queue entry layout.
package ulpb_def;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] T_IDLE    = 3'd0;
    localparam logic [2:0] T_REQ     = 3'd1;
    localparam logic [2:0] T_ACKLOW  = 3'd2;
    localparam logic [2:0] T_NEXT    = 3'd3;
    localparam logic [2:0] T_RESP    = 3'd4;
    localparam logic [2:0] T_RESPLOW = 3'd5;
    localparam logic [2:0] T_FLUSH   = 3'd6;

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_ACK    = 2'd1;
    localparam logic [1:0] R_ACKLOW = 2'd2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } rx_entry_t;

endpackage

// File: rtl/ulpb_lc_rx_fifo.sv
// RX word queue between the bus controller and the host; head is
// presented combinationally, pointers wrap on the power-of-two depth.
module ulpb_lc_rx_fifo
    import ulpb_def::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  rx_entry_t entry_i,
    input  logic      pop_i,
    output rx_entry_t head_o,
    output logic      valid_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= entry_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ulpb_lc_msg_engine.sv
// ULPB layer-controller message engine: host word streams to/from the
// bus controller over 4-phase REQ/ACK handshakes on synchronized strobes.
module ulpb_lc_msg_engine
    import ulpb_def::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HOST_TX_VALID,
    input  logic [ADDR_WIDTH-1:0] HOST_TX_ADDR,
    input  logic [DATA_WIDTH-1:0] HOST_TX_DATA,
    input  logic                  HOST_TX_LAST,
    input  logic                  HOST_TX_PRIORITY,
    output logic                  HOST_TX_READY,
    output logic                  HOST_TX_DONE,
    output logic                  HOST_TX_FAIL,
    output logic                  HOST_RX_VALID,
    output logic [ADDR_WIDTH-1:0] HOST_RX_ADDR,
    output logic [DATA_WIDTH-1:0] HOST_RX_DATA,
    output logic                  HOST_RX_LAST,
    input  logic                  HOST_RX_READY,
    output logic                  HOST_RX_FAIL,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_PEND,
    output logic                  TX_REQ,
    output logic                  PRIORITY,
    input  logic                  TX_ACK,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_REQ,
    input  logic                  RX_PEND,
    input  logic                  RX_FAIL,
    output logic                  RX_ACK
);

    logic [4:0] sync1_q, sync2_q;
    logic tx_ack_s, tx_succ_s, tx_fail_s, rx_req_s, rx_fail_s;

    logic [2:0]            t_state_q, t_state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic pend_q, pend_d, prio_q, prio_d, req_q, req_d;
    logic rack_q, rack_d, fail_q, fail_d, rdy_q, rdy_d;
    logic done_q, done_d, hfail_q, hfail_d, accept;

    logic [1:0] r_state_q, r_state_d;
    logic       rx_ack_q, rx_ack_d, rx_fail_q, rx_fail_d;
    logic       push, pop, fifo_valid, fifo_full;
    rx_entry_t  push_entry, head;

    assign {tx_ack_s, tx_succ_s, tx_fail_s, rx_req_s, rx_fail_s} = sync2_q;

    // READY is a registered pulse, so a word is taken only once it has
    // been seen low again; the host has then moved on to its next word.
    assign accept = HOST_TX_VALID && !rdy_q;

    always_comb begin
        t_state_d = t_state_q;
        addr_d = addr_q;
        data_d = data_q;
        pend_d = pend_q;
        prio_d = prio_q;
        req_d = req_q;
        rack_d = rack_q;
        fail_d = fail_q;
        rdy_d = 1'b0;
        done_d = 1'b0;
        hfail_d = 1'b0;
        unique case (t_state_q)
            T_IDLE, T_NEXT: begin
                if (t_state_q == T_NEXT && tx_fail_s) begin
                    t_state_d = T_RESP;
                end else if (accept) begin
                    if (t_state_q == T_IDLE) addr_d = HOST_TX_ADDR;
                    data_d = HOST_TX_DATA;
                    prio_d = HOST_TX_PRIORITY;
                    pend_d = ~HOST_TX_LAST;
                    req_d = 1'b1;
                    rdy_d = 1'b1;
                    t_state_d = T_REQ;
                end
            end
            T_REQ: begin
                if (tx_fail_s) begin
                    req_d = 1'b0;
                    t_state_d = T_RESP;
                end else if (tx_ack_s) begin
                    req_d = 1'b0;
                    t_state_d = T_ACKLOW;
                end
            end
            T_ACKLOW: begin
                if (tx_fail_s) t_state_d = T_RESP;
                else if (!tx_ack_s) t_state_d = pend_q ? T_NEXT : T_RESP;
            end
            T_RESP: begin
                if (tx_succ_s || tx_fail_s) begin
                    fail_d = tx_fail_s;
                    rack_d = 1'b1;
                    t_state_d = T_RESPLOW;
                end
            end
            T_RESPLOW: begin
                if (!tx_succ_s && !tx_fail_s) begin
                    rack_d = 1'b0;
                    done_d = 1'b1;
                    hfail_d = fail_q;
                    t_state_d = pend_q ? T_FLUSH : T_IDLE;
                end
            end
            T_FLUSH: begin
                if (accept) begin
                    rdy_d = 1'b1;
                    if (HOST_TX_LAST) begin
                        pend_d = 1'b0;
                        t_state_d = T_IDLE;
                    end
                end
            end
            default: t_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rx_ack_d = rx_ack_q;
        rx_fail_d = 1'b0;
        push = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (rx_req_s && rx_fail_s) begin
                    rx_fail_d = 1'b1;
                    rx_ack_d = 1'b1;
                    r_state_d = R_ACK;
                end else if (rx_req_s && !fifo_full) begin
                    push = 1'b1;
                    rx_ack_d = 1'b1;
                    r_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (!rx_req_s) begin
                    rx_ack_d = 1'b0;
                    r_state_d = R_ACKLOW;
                end
            end
            R_ACKLOW: r_state_d = R_IDLE;
            default:  r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            t_state_q <= T_IDLE;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= 1'b0;
            prio_q <= 1'b0;
            req_q <= 1'b0;
            rack_q <= 1'b0;
            fail_q <= 1'b0;
            rdy_q <= 1'b0;
            done_q <= 1'b0;
            hfail_q <= 1'b0;
            r_state_q <= R_IDLE;
            rx_ack_q <= 1'b0;
            rx_fail_q <= 1'b0;
        end else begin
            sync1_q <= {TX_ACK, TX_SUCC, TX_FAIL, RX_REQ, RX_FAIL};
            sync2_q <= sync1_q;
            t_state_q <= t_state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            pend_q <= pend_d;
            prio_q <= prio_d;
            req_q <= req_d;
            rack_q <= rack_d;
            fail_q <= fail_d;
            rdy_q <= rdy_d;
            done_q <= done_d;
            hfail_q <= hfail_d;
            r_state_q <= r_state_d;
            rx_ack_q <= rx_ack_d;
            rx_fail_q <= rx_fail_d;
        end
    end

    assign push_entry = '{addr: RX_ADDR, data: RX_DATA, last: ~RX_PEND};
    assign pop = fifo_valid && HOST_RX_READY;

    ulpb_lc_rx_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .push_i (push),
        .entry_i(push_entry),
        .pop_i  (pop),
        .head_o (head),
        .valid_o(fifo_valid),
        .full_o (fifo_full)
    );

    assign HOST_TX_READY = rdy_q;
    assign HOST_TX_DONE  = done_q;
    assign HOST_TX_FAIL  = hfail_q;
    assign TX_ADDR       = addr_q;
    assign TX_DATA       = data_q;
    assign TX_PEND       = pend_q;
    assign TX_REQ        = req_q;
    assign PRIORITY      = prio_q;
    assign TX_RESP_ACK   = rack_q;
    assign RX_ACK        = rx_ack_q;
    assign HOST_RX_FAIL  = rx_fail_q;
    assign HOST_RX_VALID = fifo_valid;
    assign HOST_RX_ADDR  = fifo_valid ? head.addr : '0;
    assign HOST_RX_DATA  = fifo_valid ? head.data : '0;
    assign HOST_RX_LAST  = fifo_valid && head.last;

endmodule

// File: tb/tb_ulpb_lc_msg_engine.sv
// Directed bench for ulpb_lc_msg_engine: host and bus-controller models
// driven from tasks, expectations hand-computed per scenario.
module tb_ulpb_lc_msg_engine;
    import ulpb_def::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        HOST_TX_VALID = 0, HOST_TX_LAST = 0, HOST_TX_PRIORITY = 0;
    logic [7:0]  HOST_TX_ADDR = '0;
    logic [31:0] HOST_TX_DATA = '0;
    logic        HOST_TX_READY, HOST_TX_DONE, HOST_TX_FAIL;
    logic        HOST_RX_VALID, HOST_RX_LAST, HOST_RX_FAIL;
    logic [7:0]  HOST_RX_ADDR;
    logic [31:0] HOST_RX_DATA;
    logic        HOST_RX_READY = 0;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK;
    logic        TX_ACK = 0, TX_SUCC = 0, TX_FAIL = 0;
    logic [7:0]  RX_ADDR = '0;
    logic [31:0] RX_DATA = '0;
    logic        RX_REQ = 0, RX_PEND = 0, RX_FAIL = 0;
    logic        RX_ACK;

    always #5 CLK = ~CLK;

    ulpb_lc_msg_engine #(.RX_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .HOST_TX_VALID(HOST_TX_VALID), .HOST_TX_ADDR(HOST_TX_ADDR),
        .HOST_TX_DATA(HOST_TX_DATA), .HOST_TX_LAST(HOST_TX_LAST),
        .HOST_TX_PRIORITY(HOST_TX_PRIORITY), .HOST_TX_READY(HOST_TX_READY),
        .HOST_TX_DONE(HOST_TX_DONE), .HOST_TX_FAIL(HOST_TX_FAIL),
        .HOST_RX_VALID(HOST_RX_VALID), .HOST_RX_ADDR(HOST_RX_ADDR),
        .HOST_RX_DATA(HOST_RX_DATA), .HOST_RX_LAST(HOST_RX_LAST),
        .HOST_RX_READY(HOST_RX_READY), .HOST_RX_FAIL(HOST_RX_FAIL),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND),
        .TX_REQ(TX_REQ), .PRIORITY(PRIORITY), .TX_ACK(TX_ACK),
        .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
        .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ),
        .RX_PEND(RX_PEND), .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Bus-side monitors
    int req_cnt = 0, done_cnt = 0, rdy_cnt = 0;
    int rxf_cnt = 0, rxf_wide = 0, hold_err = 0;
    logic last_fail = 0, req_prev = 0, rxf_prev = 0;
    logic [7:0] h_a;
    logic [31:0] h_d;
    logic h_p, h_pr;

    always @(negedge CLK) begin
        if (TX_REQ && !req_prev) begin
            req_cnt++;
            h_a = TX_ADDR; h_d = TX_DATA; h_p = TX_PEND; h_pr = PRIORITY;
        end else if (TX_REQ && {TX_ADDR, TX_DATA, TX_PEND, PRIORITY}
                               !== {h_a, h_d, h_p, h_pr}) begin
            hold_err++;
        end
        req_prev = TX_REQ;
        if (HOST_TX_DONE) begin
            done_cnt++;
            last_fail = HOST_TX_FAIL;
        end
        if (HOST_TX_READY) rdy_cnt++;
        if (HOST_RX_FAIL) begin
            rxf_cnt++;
            if (rxf_prev) rxf_wide++;
        end
        rxf_prev = HOST_RX_FAIL;
    end

    localparam int S_TXREQ = 0, S_RESP = 1, S_RXACK = 2;

    function automatic logic sig(input int s);
        case (s)
            S_TXREQ: return TX_REQ;
            S_RESP:  return TX_RESP_ACK;
            default: return RX_ACK;
        endcase
    endfunction

    task automatic wait_for(input int s, input logic lvl, input string tag);
        int n = 0;
        while (sig(s) !== lvl && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (sig(s) !== lvl) chk(tag, sig(s), lvl);
    endtask

    function automatic logic [14:0] outs();
        return {HOST_TX_READY, HOST_TX_DONE, HOST_TX_FAIL, HOST_RX_VALID,
                HOST_RX_LAST, HOST_RX_FAIL, TX_PEND, TX_REQ, PRIORITY,
                TX_RESP_ACK, RX_ACK, |TX_ADDR, |TX_DATA, |HOST_RX_ADDR,
                |HOST_RX_DATA};
    endfunction

    logic [31:0] h_words [4];
    logic [7:0]  bc_addr [4];
    logic [31:0] bc_data [4];
    logic [3:0]  bc_pend;
    logic        bc_prio;

    task automatic host_send(input int n, input logic [7:0] a);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            HOST_TX_VALID = 1'b1;
            HOST_TX_ADDR = (i == 0) ? a : 8'hFF;
            HOST_TX_DATA = h_words[i];
            HOST_TX_LAST = (i == n - 1);
            do begin
                @(negedge CLK);
                k++;
            end while (!HOST_TX_READY && k < 200);
            if (!HOST_TX_READY) chk("host_ready_timeout", 0, 1);
        end
        HOST_TX_VALID = 1'b0;
        HOST_TX_LAST = 1'b0;
    endtask

    task automatic bc_tx(input int n, input int fail_at);
        for (int i = 1; i <= n; i++) begin
            wait_for(S_TXREQ, 1'b1, "bc_req_timeout");
            if (i == fail_at) begin
                TX_FAIL = 1'b1;
                wait_for(S_RESP, 1'b1, "bc_fresp_timeout");
                TX_FAIL = 1'b0;
                wait_for(S_RESP, 1'b0, "bc_fresp0_timeout");
                return;
            end
            bc_addr[i-1] = TX_ADDR;
            bc_data[i-1] = TX_DATA;
            bc_pend[i-1] = TX_PEND;
            bc_prio = PRIORITY;
            TX_ACK = 1'b1;
            wait_for(S_TXREQ, 1'b0, "bc_reqlow_timeout");
            TX_ACK = 1'b0;
            if (!bc_pend[i-1]) begin
                TX_SUCC = 1'b1;
                wait_for(S_RESP, 1'b1, "bc_resp_timeout");
                TX_SUCC = 1'b0;
                wait_for(S_RESP, 1'b0, "bc_resp0_timeout");
            end
        end
    endtask

    task automatic rx_word(input logic [7:0] a, input logic [31:0] d,
                           input logic pend, input logic fl);
        RX_ADDR = a;
        RX_DATA = d;
        RX_PEND = pend;
        RX_FAIL = fl;
        RX_REQ = 1'b1;
        wait_for(S_RXACK, 1'b1, "rx_ack_timeout");
        RX_REQ = 1'b0;
        RX_FAIL = 1'b0;
        wait_for(S_RXACK, 1'b0, "rx_ack0_timeout");
    endtask

    task automatic rx_read(input int i);
        chk("rx_valid", HOST_RX_VALID, 1'b1);
        chk("rx_word", {HOST_RX_ADDR, HOST_RX_DATA, HOST_RX_LAST},
            {8'h80 + 8'(i), 32'hC0DE_0000 + 32'(i), i == 4});
        HOST_RX_READY = 1'b1;
        @(negedge CLK);
        HOST_RX_READY = 1'b0;
    endtask

    int r0, d0, y0, f0, cnt;

    initial begin
        // Reset with host pushing: nothing may leak out
        HOST_TX_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_outs", outs(), '0);
        HOST_TX_VALID = 1'b0;
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_outs", outs(), '0);

        // Single-word message
        r0 = req_cnt; d0 = done_cnt;
        h_words[0] = 32'hDEADBEEF;
        fork
            host_send(1, 8'h12);
            bc_tx(1, 0);
        join
        repeat (4) @(negedge CLK);
        chk("w1_reqs", req_cnt - r0, 1);
        chk("w1_pend", bc_pend[0], 1'b0);
        chk("w1_addr", bc_addr[0], 8'h12);
        chk("w1_data", bc_data[0], 32'hDEADBEEF);
        chk("w1_done", done_cnt - d0, 1);
        chk("w1_fail", last_fail, 1'b0);

        // Three-word message, later host ADDR ignored
        r0 = req_cnt; d0 = done_cnt;
        HOST_TX_PRIORITY = 1'b1;
        h_words[0] = 32'h11111111;
        h_words[1] = 32'h22222222;
        h_words[2] = 32'h33333333;
        fork
            host_send(3, 8'h34);
            bc_tx(3, 0);
        join
        repeat (4) @(negedge CLK);
        chk("w3_reqs", req_cnt - r0, 3);
        chk("w3_pend", bc_pend[2:0], 3'b011);
        chk("w3_addr", {bc_addr[0], bc_addr[1], bc_addr[2]}, 24'h343434);
        chk("w3_data1", bc_data[1], 32'h22222222);
        chk("w3_data2", bc_data[2], 32'h33333333);
        chk("w3_prio", bc_prio, 1'b1);
        chk("w3_done", done_cnt - d0, 1);
        chk("w3_fail", last_fail, 1'b0);
        chk("tx_hold", hold_err, 0);

        // Failure on word 2 of 3: response handshake, flush of the rest
        r0 = req_cnt; d0 = done_cnt; y0 = rdy_cnt;
        HOST_TX_PRIORITY = 1'b0;
        h_words[0] = 32'hAAAA0001;
        h_words[1] = 32'hAAAA0002;
        h_words[2] = 32'hAAAA0003;
        fork
            host_send(3, 8'h56);
            bc_tx(3, 2);
        join
        repeat (30) @(negedge CLK);
        chk("wf_reqs", req_cnt - r0, 2);
        chk("wf_data0", bc_data[0], 32'hAAAA0001);
        chk("wf_done", done_cnt - d0, 1);
        chk("wf_fail", last_fail, 1'b1);
        chk("wf_ready", rdy_cnt - y0, 3);
        chk("wf_req_idle", TX_REQ, 1'b0);

        // RX: fill the 4-deep queue, 5th word stalls until a pop
        for (int i = 0; i < 4; i++)
            rx_word(8'h80 + 8'(i), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0);
        RX_ADDR = 8'h84;
        RX_DATA = 32'hC0DE_0004;
        RX_PEND = 1'b0;
        RX_REQ = 1'b1;
        repeat (20) @(negedge CLK);
        chk("rx_stall", RX_ACK, 1'b0);
        rx_read(0);
        wait_for(S_RXACK, 1'b1, "rx5_ack_timeout");
        chk("rx5_ack", RX_ACK, 1'b1);
        RX_REQ = 1'b0;
        wait_for(S_RXACK, 1'b0, "rx5_ack0_timeout");
        repeat (2) @(negedge CLK);
        for (int i = 1; i < 5; i++) rx_read(i);
        chk("rx_empty", HOST_RX_VALID, 1'b0);

        // RX abort: pulse to host, queued words untouched
        f0 = rxf_cnt;
        rx_word(8'h90, 32'h90, 1'b1, 1'b0);
        rx_word(8'h91, 32'h91, 1'b1, 1'b0);
        rx_word(8'h92, 32'h92, 1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        chk("rxf_pulse", rxf_cnt - f0, 1);
        chk("rxf_width", rxf_wide, 0);
        cnt = 0;
        while (HOST_RX_VALID && cnt < 10) begin
            HOST_RX_READY = 1'b1;
            @(negedge CLK);
            cnt++;
        end
        HOST_RX_READY = 1'b0;
        chk("rxf_count", cnt, 2);

        // Reset while TX_REQ is up, then a clean message
        d0 = done_cnt;
        HOST_TX_VALID = 1'b1;
        HOST_TX_ADDR = 8'h77;
        HOST_TX_DATA = 32'h12345678;
        HOST_TX_LAST = 1'b1;
        wait_for(S_TXREQ, 1'b1, "rst_req_timeout");
        HOST_TX_VALID = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_outs", outs(), '0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        chk("rst_nodone", done_cnt - d0, 0);
        chk("rst_req_low", TX_REQ, 1'b0);
        r0 = req_cnt;
        h_words[0] = 32'hCAFEF00D;
        fork
            host_send(1, 8'h9A);
            bc_tx(1, 0);
        join
        repeat (4) @(negedge CLK);
        chk("post_rst_reqs", req_cnt - r0, 1);
        chk("post_rst_data", {bc_addr[0], bc_data[0]}, {8'h9A, 32'hCAFEF00D});
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_fail", last_fail, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ulpb_lc_msg_engine.md
ULPB_LC_MSG_ENGINE -- requirements
Module: ulpb_lc_msg_engine

Interface
REQ-001 SHALL have ports: CLK in 1, sole clock; RESET in 1, synchronous active-high reset.
REQ-002 SHALL have host TX ports: HOST_TX_VALID in 1; HOST_TX_ADDR in ADDR_WIDTH; HOST_TX_DATA in DATA_WIDTH; HOST_TX_LAST in 1; HOST_TX_PRIORITY in 1; HOST_TX_READY out 1 (word accepted); HOST_TX_DONE out 1 (message-end pulse); HOST_TX_FAIL out 1 (valid with DONE).
REQ-003 SHALL have host RX ports: HOST_RX_VALID out 1; HOST_RX_ADDR out ADDR_WIDTH; HOST_RX_DATA out DATA_WIDTH; HOST_RX_LAST out 1; HOST_RX_READY in 1; HOST_RX_FAIL out 1 (pulse, message aborted).
REQ-004 SHALL have BC-facing TX ports: TX_ADDR out ADDR_WIDTH; TX_DATA out DATA_WIDTH; TX_PEND out 1; TX_REQ out 1; PRIORITY out 1; TX_ACK in 1; TX_SUCC in 1; TX_FAIL in 1; TX_RESP_ACK out 1.
REQ-005 SHALL have BC-facing RX ports: RX_ADDR in ADDR_WIDTH; RX_DATA in DATA_WIDTH; RX_REQ in 1; RX_PEND in 1; RX_FAIL in 1; RX_ACK out 1.
REQ-006 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries (power of two, >=2).

Function
REQ-007 SHALL pass TX_ACK, TX_SUCC, TX_FAIL, RX_REQ, RX_FAIL through 2-flop synchronizers; all decisions use synchronized values; multi-bit RX/TX buses sampled only while the paired REQ is high (stable by protocol).
REQ-008 TX FSM states SHALL be T_IDLE, T_REQ, T_ACKLOW, T_NEXT, T_RESP, T_RESPLOW, T_FLUSH.
REQ-009 T_IDLE/T_NEXT: on HOST_TX_VALID, SHALL register ADDR (first word only), DATA, PRIORITY, TX_PEND=~HOST_TX_LAST, assert TX_REQ next cycle, pulse HOST_TX_READY one cycle, go T_REQ.
REQ-010 T_REQ: on sync TX_ACK=1, SHALL drop TX_REQ, go T_ACKLOW; T_ACKLOW: on sync TX_ACK=0, go T_NEXT if TX_PEND else T_RESP.
REQ-011 T_RESP: on sync TX_SUCC or TX_FAIL, SHALL latch fail=TX_FAIL, assert TX_RESP_ACK, go T_RESPLOW; T_RESPLOW: when both low, drop TX_RESP_ACK, pulse HOST_TX_DONE one cycle with HOST_TX_FAIL=latched fail, go T_IDLE (or T_FLUSH if host message unfinished).
REQ-012 Sync TX_FAIL=1 in T_REQ/T_ACKLOW/T_NEXT SHALL drop TX_REQ immediately and enter T_RESP handling with fail=1.
REQ-013 T_FLUSH: SHALL pulse HOST_TX_READY per HOST_TX_VALID, discard words through HOST_TX_LAST, then T_IDLE; no TX_REQ asserted.
REQ-014 TX_ADDR/DATA/PEND/PRIORITY SHALL be held constant while TX_REQ=1.
REQ-015 RX FSM states SHALL be R_IDLE, R_ACK, R_ACKLOW.
REQ-016 R_IDLE: on sync RX_REQ=1 with RX_FAIL=0 and FIFO not full, SHALL push {RX_ADDR, RX_DATA, LAST=~RX_PEND}, assert RX_ACK, go R_ACK; FIFO full SHALL stall (no ACK) until a pop frees an entry.
REQ-017 R_IDLE: on sync RX_REQ=1 with RX_FAIL=1, SHALL push nothing, pulse HOST_RX_FAIL, assert RX_ACK, go R_ACK; words already queued remain; host discards partial message.
REQ-018 R_ACK: on sync RX_REQ=0, SHALL drop RX_ACK, go R_ACKLOW→R_IDLE next cycle.
REQ-019 FIFO SHALL show head on HOST_RX_*; pop when HOST_RX_VALID&&HOST_RX_READY; simultaneous push/pop on full SHALL NOT be allowed (push waits one cycle); pointers wrap modulo RX_DEPTH; count width clog2(RX_DEPTH)+1.
REQ-020 TX and RX FSMs SHALL operate independently and concurrently.

Reset
REQ-021 RESET=1 SHALL clear all outputs to 0, FSMs to T_IDLE/R_IDLE, FIFO empty, synchronizers 0, within the same edge; mid-message reset drops TX_REQ/RX_ACK/TX_RESP_ACK with no HOST_TX_DONE pulse.

Structure
REQ-022 ADDR_WIDTH, DATA_WIDTH SHALL come from the shared ulpb_def definitions; TX/RX state encodings SHALL live in that shared definitions file.
REQ-023 RX buffer SHALL be one sub-module ulpb_lc_rx_fifo; synchronizers inline.

Verification
REQ-024 Single word: host sends ADDR=8'h12, DATA=32'hDEADBEEF, LAST=1; BC ACKs then TX_SUCC -> TX_PEND=0, one TX_REQ cycle pair, HOST_TX_DONE=1 with HOST_TX_FAIL=0.
REQ-025 Three-word message -> TX_PEND=1,1,0 across three REQ/ACK pairs, ADDR constant, one DONE.
REQ-026 TX_FAIL after word 1 of 3 -> TX_REQ dropped, TX_RESP_ACK handshake, HOST_TX_FAIL=1, words 2-3 flushed with READY, no further TX_REQ.
REQ-027 BC sends 5 RX words with host READY=0, RX_DEPTH=4 -> 4 ACKs, 5th RX_REQ unacked until one pop; host reads all 5 in order, LAST only on 5th.
REQ-028 RX_REQ with RX_FAIL=1 -> HOST_RX_FAIL one-cycle pulse, RX_ACK handshake, FIFO count unchanged.
REQ-029 RESET asserted in T_REQ -> next cycle TX_REQ=0, all outputs 0, new message proceeds normally.
